// File: rtl/tolower_pkg.sv
// tolower_pkg: shared byte type, ASCII bounds and case-bit helpers for the lowercase stream
package tolower_pkg;
    typedef logic [7:0] byte_t;
    localparam byte_t ASCII_UPPER_A = 8'h41;
    localparam byte_t ASCII_UPPER_Z = 8'h5A;
    localparam int    CASE_BIT      = 5;
    function automatic logic is_upper(input byte_t b);
        return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
    endfunction
    function automatic byte_t set_case_bit(input byte_t b);
        return b | byte_t'(1 << CASE_BIT);
    endfunction
endpackage

// File: rtl/tolower_fifo.sv
// tolower_fifo: byte FIFO with registered occupancy; ready/valid come only from stored state
import tolower_pkg::*;
module tolower_fifo #(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  i_push,
    input  byte_t i_data,
    input  logic  i_pop,
    output byte_t o_data,
    output logic  o_ready,
    output logic  o_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    byte_t           r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push;
    logic            w_pop;
    assign o_ready = r_count < CW'(DEPTH);
    assign o_valid = r_count != '0;
    assign w_push  = i_push && o_ready;
    assign w_pop   = i_pop && o_valid;
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    // pointers wrap naturally at DEPTH; occupancy nets out simultaneous push and pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count  <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
    // storage needs no reset: unread slots are masked by o_valid
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/tolower_stream.sv
// tolower_stream: converts 'A'..'Z' to lowercase on the way into a FIFO and counts traffic
import tolower_pkg::*;
module tolower_stream #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  byte_t            in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output byte_t            out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] conv_cnt,
    output logic [CNT_W-1:0] byte_cnt
);
    logic             w_in_fire;
    logic             w_convert;
    byte_t            w_wr_data;
    logic [CNT_W-1:0] r_conv_cnt;
    logic [CNT_W-1:0] r_byte_cnt;
    assign w_in_fire = in_valid && in_ready;
    assign w_convert = en && is_upper(in_data);
    assign w_wr_data = w_convert ? set_case_bit(in_data) : in_data;
    assign conv_cnt  = r_conv_cnt;
    assign byte_cnt  = r_byte_cnt;
    tolower_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (w_wr_data),
        .i_pop   (out_ready),
        .o_data  (out_data),
        .o_ready (in_ready),
        .o_valid (out_valid)
    );
    // saturating statistics counters, advanced only by accepted bytes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte_cnt <= '0;
            r_conv_cnt <= '0;
        end else begin
            r_byte_cnt <= (w_in_fire && r_byte_cnt != '1) ? r_byte_cnt + 1'b1 : r_byte_cnt;
            r_conv_cnt <= (w_in_fire && w_convert && r_conv_cnt != '1) ? r_conv_cnt + 1'b1 : r_conv_cnt;
        end
    end
endmodule

// File: doc/tolower_stream.md
TOLOWER_STREAM -- requirements
Module: tolower_stream

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the buffer depth in bytes; legal values are powers of two, at least 2.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of both statistics counters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 en  input  1  SHALL select the mode: 1 = convert case, 0 = pass bytes through unchanged; it is sampled with each accepted byte.
REQ-006 in_data  input  8  SHALL carry the ASCII byte being offered.
REQ-007 in_valid  input  1  SHALL mark in_data as valid.
REQ-008 in_ready  output  1  SHALL indicate the block can accept a byte.
REQ-009 out_data  output  8  SHALL carry the converted byte.
REQ-010 out_valid  output  1  SHALL mark out_data as valid.
REQ-011 out_ready  input  1  SHALL indicate the downstream consumer accepts out_data.
REQ-012 conv_cnt  output  CNT_W  SHALL hold the number of bytes actually converted.
REQ-013 byte_cnt  output  CNT_W  SHALL hold the total number of bytes accepted.

Function
REQ-014 An input transfer SHALL occur when in_valid and in_ready are both 1; an output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 Conversion SHALL apply only to bytes 0x41..0x5A ('A'..'Z') with en=1: set bit 5 (add 0x20); all other bytes SHALL pass unchanged, including 0x40, 0x5B, 0x61..0x7A and bytes with bit 7 set.
REQ-016 Conversion SHALL be applied at write time; the buffer SHALL store converted bytes.
REQ-017 Latency SHALL be exactly one cycle: a byte accepted at edge N SHALL appear on out_data with out_valid=1 after edge N; no combinational path from in_* to out_*.
REQ-018 Ordering SHALL be strict FIFO; no byte dropped or duplicated.
REQ-019 in_ready SHALL be 1 exactly when occupancy < DEPTH; it SHALL depend only on registered state, not on out_ready.
REQ-020 When full, a same-cycle output transfer SHALL NOT enable an input transfer; the input is accepted the following cycle.
REQ-021 When not full and not empty, a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-022 out_valid SHALL be 1 exactly when occupancy > 0; out_data SHALL hold steady while out_valid=1 and out_ready=0.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with log2(DEPTH)+1 bits.
REQ-024 byte_cnt SHALL increment on every input transfer.
REQ-025 conv_cnt SHALL increment on input transfers that convert a byte.
REQ-026 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 Changing en mid-stream SHALL affect only bytes accepted after the change.

Reset
REQ-028 Asserting rst SHALL immediately empty the buffer and clear both pointers.
REQ-029 During and after reset: out_valid=0, out_data=0x00, in_ready=1, conv_cnt=0, byte_cnt=0.
REQ-030 Reset during streaming SHALL discard all buffered bytes; none SHALL appear after deassertion.
REQ-031 No transfer SHALL occur while rst=1.

Structure
REQ-032 Package tolower_pkg SHALL hold ASCII_UPPER_A=8'h41, ASCII_UPPER_Z=8'h5A, CASE_BIT=5, and a byte typedef.
REQ-033 Buffering SHALL reside in one sub-module, tolower_fifo (parameterised by DEPTH, width 8).
REQ-034 Classification and conversion logic and the counters SHALL reside in tolower_stream.

Verification
REQ-035 Scenario 1: with en=1, out_ready=1, stream "Hello, WORLD!" -> output is "hello, world!", byte_cnt=13, conv_cnt=6.
REQ-036 Scenario 2: boundary bytes 0x40, 0x41, 0x5A, 0x5B, 0x61, 0xC1 -> output 0x40, 0x61, 0x7A, 0x5B, 0x61, 0xC1, conv_cnt=2.
REQ-037 Scenario 3: out_ready=0, push 5 bytes with DEPTH=4 -> in_ready drops after the 4th; raise out_ready -> all 5 bytes emerge in order.
REQ-038 Scenario 4: full buffer with simultaneous pop and in_valid -> no push that cycle, push on the next; occupancy sequence 4, 3, 4.
REQ-039 Scenario 5: en=0 with input "ABC" -> output "ABC", conv_cnt unchanged, byte_cnt increments by 3.
REQ-040 Scenario 6: assert rst with 3 bytes buffered -> out_valid=0 and counters=0 immediately, and no stale bytes after release.
